m6809_alu_seq: RTL

M6809_ALU_SEQ -- requirements
Module: m6809_alu_seq

---
 rtl/m6809_alu_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/m6809_alu_seq.sv
// rtl/m6809_alu_seq.sv - 6809 accumulator subset sequencer driving an external ALU
module m6809_alu_seq #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_op7,
    output logic        alu_c_in,
    output logic        alu_v_in,
    output logic        alu_h_in,
    input  logic [7:0]  alu_res,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        alu_h,
    output logic [7:0]  reg_a,
    output logic [7:0]  reg_b,
    output logic [7:0]  cc,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_OPND,
        S_EXEC,
        S_HALT
    } state_t;

    // One bit per legal low nibble, indexed by opcode[3:0]
    localparam logic [15:0] INH_LEGAL = 16'hB7D9;
    localparam logic [15:0] IMM_LEGAL = 16'h0F77;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  opcode;
    logic [7:0]  operand;
    logic        rd_req;

    logic [3:0]  lo_nib;
    logic [3:0]  hi_nib;
    logic        is_inh;
    logic        is_imm;
    logic        sel_b;
    logic        is_ld;
    logic        no_wb;
    logic [7:0]  acc;

    always_comb begin
        lo_nib = opcode[3:0];
        hi_nib = opcode[7:4];
        is_inh = (hi_nib == 4'h4) || (hi_nib == 4'h5);
        is_imm = (hi_nib == 4'h8) || (hi_nib == 4'hC);
        sel_b  = is_imm ? opcode[6] : opcode[4];
        is_ld  = opcode[7] && (lo_nib == 4'h6);
        // CMP and BIT exist only as immediates, TST only as inherent
        no_wb  = (opcode[7] && ((lo_nib == 4'h1) || (lo_nib == 4'h5)))
              || (!opcode[7] && (lo_nib == 4'hD));
        acc    = sel_b ? reg_b : reg_a;
    end

    always_comb begin
        alu_op   = lo_nib;
        alu_op7  = opcode[7];
        alu_a    = is_ld ? operand : acc;
        alu_b    = is_imm ? operand : 8'h00;
        alu_c_in = cc[0];
        alu_v_in = cc[1];
        alu_h_in = cc[5];
        mem_addr = pc;
        halted   = (state == S_HALT);
    end

    always_comb begin
        state_nx = state;
        rd_req   = 1'b0;
        case (state)
            S_FETCH: begin
                rd_req = 1'b1;
                if (mem_ack) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == 8'h12)                   state_nx = S_FETCH;
                else if (is_inh && INH_LEGAL[lo_nib])  state_nx = S_EXEC;
                else if (is_imm && IMM_LEGAL[lo_nib])  state_nx = S_OPND;
                else                                   state_nx = S_HALT;
            end
            S_OPND: begin
                rd_req = 1'b1;
                if (mem_ack) state_nx = S_EXEC;
            end
            S_EXEC:  state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_HALT;
        endcase
        mem_rd = rd_req && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            reg_a   <= 8'h00;
            reg_b   <= 8'h00;
            cc      <= 8'h50;
            opcode  <= 8'h00;
            operand <= 8'h00;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        opcode <= mem_rdata;
                        pc     <= pc + 16'd1;
                    end
                end
                S_OPND: begin
                    if (mem_ack) begin
                        operand <= mem_rdata;
                        pc      <= pc + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (!no_wb) begin
                        if (sel_b) reg_b <= alu_res;
                        else       reg_a <= alu_res;
                    end
                    cc <= {cc[7:6], alu_h, cc[4], alu_n, alu_z,
                           is_ld ? 1'b0 : alu_v, alu_c};
                end
                default: ;
            endcase
        end
    end

endmodule
